// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//
// Multi-cycle unsigned shift-and-add multiplier controller. It borrows the
// shared execute-stage ALU adder for one add per cycle, and produces a
// 2*DATA_BITS product from two DATA_BITS operands. A multiply takes
// DATA_BITS cycles in RUN, followed by one DONE cycle.
//
// Optional feature macro: ALU_MUL_ZERO_SKIP_EN
//   When this macro is defined, a multiply with a zero operand skips RUN.
//   It goes straight to DONE with product = 0.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        multiply request, honoured only while ready
//   op_a, op_b   multiplicand / multiplier, sampled on the accepting edge
//   ready        high in IDLE
//   done         one-cycle pulse, product valid
//   product      {acc_hi, acc_lo}, held until the next accepted start
//   alu_own      high in RUN, steers the ALU input mux to this block
//   alu_a/alu_b  ALU operands (zero outside RUN)
//   alu_cin      ALU carry in, always 0
//   alu_result   ALU sum
//   alu_cout     ALU carry out
module alu_mul_sequencer #(
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DATA_BITS-1:0]   op_a,
    input  logic [DATA_BITS-1:0]   op_b,
    output logic                   ready,
    output logic                   done,
    output logic [2*DATA_BITS-1:0] product,
    output logic                   alu_own,
    output logic [DATA_BITS-1:0]   alu_a,
    output logic [DATA_BITS-1:0]   alu_b,
    output logic                   alu_cin,
    input  logic [DATA_BITS-1:0]   alu_result,
    input  logic                   alu_cout
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mcand;
    logic [DATA_BITS-1:0] acc_hi;
    logic [DATA_BITS-1:0] acc_lo;
    logic [CNT_W-1:0]     cnt;
    logic                 zero_skip;

`ifdef ALU_MUL_ZERO_SKIP_EN
    assign zero_skip = (op_a == '0) || (op_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            alu_own <= 1'b0;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done    <= 1'b0;
                    alu_own <= 1'b0;
                    if (start) begin
                        mcand  <= op_a;
                        acc_hi <= '0;
                        // A skipped multiply must present product = 0 at done.
                        acc_lo <= zero_skip ? '0 : op_b;
                        cnt    <= CNT_W'(DATA_BITS);
                        if (zero_skip) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            alu_own <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Shift the 2N+1-bit {cout, sum, acc_lo} right by one.
                    // The adder carry becomes the new acc_hi MSB, and the
                    // consumed multiplier bit falls off acc_lo.
                    acc_hi <= {alu_cout, alu_result[DATA_BITS-1:1]};
                    acc_lo <= {alu_result[0], acc_lo[DATA_BITS-1:1]};
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        alu_own <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    alu_own <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = (state == IDLE);
    assign product = {acc_hi, acc_lo};

    // alu_own is high exactly in RUN, so it gates the ALU operands.
    assign alu_a   = alu_own ? acc_hi : '0;
    assign alu_b   = (alu_own && acc_lo[0]) ? mcand : '0;
    assign alu_cin = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed testbench for alu_mul_sequencer (DATA_BITS = 8).
// A combinational adder stands in for the shared ALU.
// Sample point i (the i-th falling edge after the accepting edge E) is cycle E+i.
module tb_alu_mul_sequencer;

    localparam int N = 8;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] product;
    logic           alu_own;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic           alu_cin;
    logic [N-1:0]   alu_result;
    logic           alu_cout;

    int checks;
    int failures;

    alu_mul_sequencer #(.DATA_BITS(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .ready      (ready),
        .done       (done),
        .product    (product),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // Shared ALU model: a plain adder.
    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start request, and return just after the accepting edge E.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        op_a    = '0;
        op_b    = '0;
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1)      begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (alu_own !== 1'b0)    begin failures++; $display("FAIL reset_alu_own got=%b exp=0", alu_own); end
        checks++; if (product !== 16'h0)   begin failures++; $display("FAIL reset_product got=%h exp=0000", product); end
        checks++; if (alu_a !== 8'h0)      begin failures++; $display("FAIL reset_alu_a got=%h exp=00", alu_a); end
        checks++; if (alu_b !== 8'h0)      begin failures++; $display("FAIL reset_alu_b got=%h exp=00", alu_b); end
        checks++; if (alu_cin !== 1'b0)    begin failures++; $display("FAIL reset_alu_cin got=%b exp=0", alu_cin); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // 13 x 11 = 143 = 0x008F
    task automatic test_basic;
        issue(8'd13, 8'd11);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++; if (alu_own !== (i <= 8)) begin failures++; $display("FAIL basic_alu_own cyc=E+%0d got=%b exp=%b", i, alu_own, (i <= 8)); end
            checks++; if (done !== (i == 9))    begin failures++; $display("FAIL basic_done cyc=E+%0d got=%b exp=%b", i, done, (i == 9)); end
            checks++; if (ready !== (i == 10))  begin failures++; $display("FAIL basic_ready cyc=E+%0d got=%b exp=%b", i, ready, (i == 10)); end
            if (i == 1) begin
                // The first multiplier bit (11 -> bit0 = 1) selects mcand = 13.
                checks++; if (alu_b !== 8'd13) begin failures++; $display("FAIL basic_alu_b_step1 got=%0d exp=13", alu_b); end
            end
            if (i == 9) begin
                checks++; if (product !== 16'h008F) begin failures++; $display("FAIL basic_product got=%h exp=008f", product); end
            end
            if (i == 10) begin
                checks++; if (alu_a !== 8'h0 || alu_b !== 8'h0) begin failures++; $display("FAIL basic_idle_alu got=%h/%h exp=00/00", alu_a, alu_b); end
            end
        end
    endtask

    // 255 x 255 = 0xFE01. Steps 2..8 each produce a carry out (7 carries).
    task automatic test_max;
        int carries;
        carries = 0;
        issue(8'hFF, 8'hFF);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (alu_own && alu_cout) carries++;
            if (i == 9) begin
                checks++; if (done !== 1'b1)        begin failures++; $display("FAIL max_done got=%b exp=1", done); end
                checks++; if (product !== 16'hFE01) begin failures++; $display("FAIL max_product got=%h exp=fe01", product); end
            end
        end
        checks++; if (carries != 7) begin failures++; $display("FAIL max_carry_steps got=%0d exp=7", carries); end
    endtask

    task automatic test_zero_operand;
        issue(8'h00, 8'h5A);
`ifdef ALU_MUL_ZERO_SKIP_EN
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            checks++; if (alu_own !== 1'b0)    begin failures++; $display("FAIL zero_alu_own cyc=E+%0d got=%b exp=0", i, alu_own); end
            checks++; if (done !== (i == 1))   begin failures++; $display("FAIL zero_done cyc=E+%0d got=%b exp=%b", i, done, (i == 1)); end
            checks++; if (ready !== (i == 2))  begin failures++; $display("FAIL zero_ready cyc=E+%0d got=%b exp=%b", i, ready, (i == 2)); end
            if (i == 1) begin
                checks++; if (product !== 16'h0) begin failures++; $display("FAIL zero_product got=%h exp=0000", product); end
            end
        end
`else
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++; if (alu_own !== (i <= 8)) begin failures++; $display("FAIL zero_alu_own cyc=E+%0d got=%b exp=%b", i, alu_own, (i <= 8)); end
            checks++; if (done !== (i == 9))    begin failures++; $display("FAIL zero_done cyc=E+%0d got=%b exp=%b", i, done, (i == 9)); end
            if (i == 9) begin
                checks++; if (product !== 16'h0) begin failures++; $display("FAIL zero_product got=%h exp=0000", product); end
            end
        end
`endif
    endtask

    // 200 x 2 = 400 = 0x0190. A start request made while the block is busy is dropped.
    task automatic test_start_while_busy;
        issue(8'd200, 8'd2);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++; if (done !== (i == 9)) begin failures++; $display("FAIL busy_done cyc=E+%0d got=%b exp=%b", i, done, (i == 9)); end
            if (i == 9) begin
                checks++; if (product !== 16'h0190) begin failures++; $display("FAIL busy_product got=%h exp=0190", product); end
                start = 1'b0;
            end
            if (i == 10) begin
                checks++; if (ready !== 1'b1)       begin failures++; $display("FAIL busy_ready got=%b exp=1", ready); end
                checks++; if (product !== 16'h0190) begin failures++; $display("FAIL busy_product_held got=%h exp=0190", product); end
            end
            if (i == 4) begin
                op_a  = 8'd3;
                op_b  = 8'd3;
                start = 1'b1;
            end
        end
        // A new request at E+10 is accepted: 3 x 3 = 9.
        issue(8'd3, 8'd3);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) begin
                checks++; if (alu_own !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL busy_accept got=own%b/rdy%b exp=own1/rdy0", alu_own, ready); end
            end
            if (j == 9) begin
                checks++; if (done !== 1'b1 || product !== 16'h0009) begin failures++; $display("FAIL busy_next got=done%b/%h exp=done1/0009", done, product); end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        issue(8'd100, 8'd100);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (product !== 16'h0) begin failures++; $display("FAIL midrst_product got=%h exp=0000", product); end
        checks++; if (alu_own !== 1'b0)  begin failures++; $display("FAIL midrst_alu_own got=%b exp=0", alu_own); end
        checks++; if (ready !== 1'b1)    begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL midrst_quiet cyc=%0d got=done%b/rdy%b exp=done0/rdy1", i, done, ready); end
        end
        // 7 x 6 = 42 = 0x002A
        issue(8'd7, 8'd6);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                checks++; if (done !== 1'b1)        begin failures++; $display("FAIL midrst_next_done got=%b exp=1", done); end
                checks++; if (product !== 16'h002A) begin failures++; $display("FAIL midrst_next_product got=%h exp=002a", product); end
            end
        end
    endtask

    // Holding start high gives one 1x1 multiply every 10 cycles.
    task automatic test_back_to_back;
        int dones;
        dones = 0;
        op_a  = 8'd1;
        op_b  = 8'd1;
        start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            checks++; if (done !== ((i % 10) == 9)) begin failures++; $display("FAIL b2b_done cyc=E+%0d got=%b exp=%b", i, done, ((i % 10) == 9)); end
            checks++; if (alu_cin !== 1'b0)         begin failures++; $display("FAIL b2b_alu_cin cyc=E+%0d got=%b exp=0", i, alu_cin); end
            if ((i % 10) == 9) begin
                checks++; if (product !== 16'h0001) begin failures++; $display("FAIL b2b_product cyc=E+%0d got=%h exp=0001", i, product); end
            end
        end
        start = 1'b0;
        checks++; if (dones != 3) begin failures++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_basic;
        test_max;
        test_zero_operand;
        test_start_while_busy;
        test_reset_mid_op;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle unsigned multiplier controller that sequences the shared `alu` adder through a shift-and-add algorithm. It produces a 2×DATA_BITS product from two DATA_BITS operands. The block sits beside the ALU in the execute stage. While the sequencer is running, `alu_own` steers the ALU input mux to this block; otherwise the normal instruction datapath drives the ALU.

## Interface
- `DATA_BITS`, default 8: operand width; the product is 2×DATA_BITS.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a multiply; honoured only when `ready`=1.
- `op_a`  in  DATA_BITS  multiplicand, sampled on the accepting edge.
- `op_b`  in  DATA_BITS  multiplier, sampled on the accepting edge.
- `ready`  out  1  high in IDLE.
- `done`  out  1  one-cycle pulse; product valid.
- `product`  out  2×DATA_BITS  result; held until the next accepted start.
- `alu_own`  out  1  high in RUN; selects this block onto the ALU inputs.
- `alu_a`, `alu_b`  out  DATA_BITS  ALU operands.
- `alu_cin`  out  1  always 0 (add only).
- `alu_result`  in  DATA_BITS  ALU sum.
- `alu_cout`  in  1  ALU carry out.

## Operation
- States: IDLE, RUN, DONE. Counter `cnt` is $clog2(DATA_BITS+1) bits wide.
- Registers: `mcand` (DATA_BITS), `acc_hi` (DATA_BITS), `acc_lo` (DATA_BITS); `product` = {acc_hi, acc_lo}.
- IDLE, `start`=1:
  - mcand←op_a, acc_hi←0, acc_lo←op_b, cnt←DATA_BITS.
  - Go to RUN.
- RUN, each cycle:
  - alu_a=acc_hi, alu_b = acc_lo[0] ? mcand : 0, alu_cin=0.
  - {acc_hi, acc_lo} ← {alu_cout, alu_result, acc_lo[DATA_BITS-1:1]}.
  - cnt←cnt−1. When cnt==1, go to DONE.
- DONE: `done`=1 for this cycle only; go to IDLE unconditionally.
- Outside RUN: alu_a=0, alu_b=0, alu_cin=0, alu_own=0. ALU outputs are ignored.
- `start` outside IDLE is ignored; it is not queued. Operand changes after acceptance have no effect.
- Arithmetic is unsigned and cannot overflow: the max product (2^N−1)² fits in 2N bits. The carry is captured every step as the new acc_hi MSB.
- The ALU is purely combinational. Its own `reset` input must be held low by the integrator whenever `alu_own`=1.

## Timing
- Reset (`reset_n`=0, async) forces:
  - state=IDLE, ready=1, done=0, alu_own=0.
  - product=0, mcand=0, cnt=0, alu_a/alu_b/alu_cin=0.
- Reset asserted mid-RUN aborts immediately. There is no done pulse and product=0.
- Latency from the accepting edge E:
  - RUN occupies cycles E+1 … E+DATA_BITS.
  - DONE occupies cycle E+DATA_BITS+1, with done=1 and the final product visible.
  - IDLE resumes at E+DATA_BITS+2; ready=1 and a new start is accepted.
- Throughput is one multiply per DATA_BITS+2 cycles.
- `ready` is combinational from the state and is low in RUN and DONE.
- `product` changes only during RUN. It is intermediate/partial there and must not be consumed until `done`.

## Configuration
- Macro `ALU_MUL_ZERO_SKIP_EN`.
- Defined: on acceptance, if op_a==0 or op_b==0, the block goes IDLE→DONE directly with product=0. done asserts on E+1 and alu_own never rises.
- Undefined: every multiply takes the full DATA_BITS RUN cycles regardless of operand values.

## Test plan
- Basic: reset, then op_a=13, op_b=11, start at edge E (DATA_BITS=8) -> alu_own high for 8 cycles; done on E+9 with product=0x008F; ready on E+10.
- Max operands: op_a=0xFF, op_b=0xFF -> product=0xFE01; verify alu_cout=1 is captured on intermediate steps.
- Zero operand: op_a=0, op_b=0x5A, with and without the macro:
  - Macro defined -> done at E+1, product=0, alu_own never high.
  - Macro undefined -> done at E+9, product=0.
- Start while busy: pulse start with op_a=3, op_b=3 at E+4 during a 200×2 multiply -> ignored; product=0x0190 at E+9; new start accepted only at E+10.
- Reset mid-operation: drop reset_n at E+5 (asynchronously, between edges) -> state IDLE, product=0, alu_own=0 at once; no done pulse; a fresh 7×6 multiply then yields 0x002A.
- Back-to-back: hold start=1 continuously with operands 1×1 -> a done pulse every 10 cycles, product=0x0001, alu_cin always 0.
